// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with stall, halt, branch and range fault
module pc_sequencer #(
  parameter int PC_W       = 10,
  parameter int IMEM_DEPTH = 1024,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  entry_addr,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_en,
  input  logic             br_abs,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One extra bit so IMEM_DEPTH == 2**PC_W is representable and never faults.
  localparam logic [PC_W:0]    DEPTH   = (PC_W+1)'(IMEM_DEPTH);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc_next, pc_step;
  logic [CYC_W-1:0]  cnt_next;
  logic              fault_next;
  logic              entry_oob, step_oob;

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign fetch_en = busy & ~stall;

  // Relative branch: offset and pc share a width, so the wrap-around sum is the sign-extended add.
  always_comb begin
    pc_step = pc + PC_W'(1);
    if (br_en) begin
      pc_step = br_abs ? br_target : pc + br_target;
    end
  end

  assign entry_oob = ({1'b0, entry_addr} >= DEPTH);
  assign step_oob  = ({1'b0, pc_step} >= DEPTH);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cycle_count;
    fault_next = fault;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          pc_next    = entry_addr;
          cnt_next   = '0;
          fault_next = entry_oob;
          state_next = entry_oob ? DONE : RUN;
        end
      end
      RUN: begin
        if (cycle_count != CYC_MAX) begin
          cnt_next = cycle_count + CYC_W'(1);
        end
        if (!stall) begin
          if (halt) begin
            state_next = DONE;
          end else begin
            pc_next = pc_step;
            if (step_oob) begin
              state_next = DONE;
              fault_next = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      cycle_count <= cnt_next;
      fault       <= fault_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (full-size and small-memory instances)
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start = 1'b0, stall = 1'b0, halt = 1'b0, br_en = 1'b0, br_abs = 1'b0;
  logic [9:0] entry_addr = '0, br_target = '0;

  logic [9:0]  a_pc, b_pc;
  logic        a_fetch_en, a_busy, a_done, a_fault;
  logic        b_fetch_en, b_busy, b_done, b_fault;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  pc_sequencer #(.PC_W(10), .IMEM_DEPTH(1024), .CYC_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .entry_addr(entry_addr), .stall(stall),
    .halt(halt), .br_en(br_en), .br_abs(br_abs), .br_target(br_target),
    .pc(a_pc), .fetch_en(a_fetch_en), .busy(a_busy), .done(a_done), .fault(a_fault),
    .cycle_count(a_cnt)
  );

  pc_sequencer #(.PC_W(10), .IMEM_DEPTH(64), .CYC_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .entry_addr(entry_addr), .stall(stall),
    .halt(halt), .br_en(br_en), .br_abs(br_abs), .br_target(br_target),
    .pc(b_pc), .fetch_en(b_fetch_en), .busy(b_busy), .done(b_done), .fault(b_fault),
    .cycle_count(b_cnt)
  );

  typedef struct packed {
    logic [9:0]  pc;
    logic        busy;
    logic        done;
    logic        fault;
    logic        fetch_en;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic       rs, st;
    logic [9:0] ea;
    logic       sl, h, be, ba;
    logic [9:0] bt;
    obs_t       exp;
  } step_t;

  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   use_b = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    if (use_b) o = '{b_pc, b_busy, b_done, b_fault, b_fetch_en, {12'd0, b_cnt}};
    else       o = '{a_pc, a_busy, a_done, a_fault, a_fetch_en, a_cnt};
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%0d busy=%b done=%b fault=%b fetch_en=%b cnt=%0d",
                     o.pc, o.busy, o.done, o.fault, o.fetch_en, o.cnt);
  endfunction

  // Expected fetch_en follows from the expected state and the stall still being driven.
  function automatic step_t stp(input logic rs, st, input int ea, input logic sl, h, be, ba,
                                input int bt, input int epc, input logic eb, ed, ef, input int ec);
    step_t s;
    s.rs = rs; s.st = st; s.ea = 10'(ea); s.sl = sl; s.h = h; s.be = be; s.ba = ba;
    s.bt = 10'(bt);
    s.exp = '{10'(epc), eb, ed, ef, eb & ~sl, 16'(ec)};
    return s;
  endfunction

  task automatic apply(input step_t s);
    reset = s.rs; start = s.st; entry_addr = s.ea; stall = s.sl;
    halt = s.h; br_en = s.be; br_abs = s.ba; br_target = s.bt;
    sb.push_back(s.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t v[$];
    obs_t  got, exp;
    use_b = 1'b0;
    v.push_back(stp(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    v.push_back(stp(0, 0, 0, 1, 1, 1, 1, 100, 0, 0, 0, 0, 0));
    v.push_back(stp(0, 0, 0, 0, 1, 1, 0, 7,   0, 0, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      got = sample(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_halt();
    step_t v[$];
    obs_t  got, exp;
    use_b = 1'b0;
    v.push_back(stp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(stp(0, 1, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0));
    v.push_back(stp(0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 1));
    v.push_back(stp(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 2));
    v.push_back(stp(0, 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 3));
    v.push_back(stp(0, 0, 0, 0, 1, 0, 0, 0, 8, 0, 1, 0, 4));
    v.push_back(stp(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0, 4));
    foreach (v[i]) begin
      apply(v[i]);
      got = sample(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL halt[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_branch();
    step_t v[$];
    obs_t  got, exp;
    use_b = 1'b0;
    v.push_back(stp(1, 0, 0,  0, 0, 0, 0, 0,     0,   0, 0, 0, 0));
    v.push_back(stp(0, 1, 20, 0, 0, 0, 0, 0,     20,  1, 0, 0, 0));
    v.push_back(stp(0, 0, 0,  0, 0, 1, 0, 'h3FD, 17,  1, 0, 0, 1));
    v.push_back(stp(0, 0, 0,  0, 0, 1, 1, 100,   100, 1, 0, 0, 2));
    v.push_back(stp(0, 0, 0,  0, 0, 1, 0, 'h3F0, 84,  1, 0, 0, 3));
    v.push_back(stp(0, 0, 0,  0, 1, 1, 1, 500,   84,  0, 1, 0, 4));
    foreach (v[i]) begin
      apply(v[i]);
      got = sample(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_stall();
    step_t v[$];
    obs_t  got, exp;
    use_b = 1'b0;
    v.push_back(stp(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    v.push_back(stp(0, 1, 9, 0, 0, 0, 0, 0,  9, 1, 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      v.push_back(stp(0, 0, 0, 1, 1, 1, 1, 40, 9, 1, 0, 0, k));
    v.push_back(stp(0, 0, 0, 0, 1, 0, 0, 0,  9, 0, 1, 0, 4));
    foreach (v[i]) begin
      apply(v[i]);
      got = sample(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_range();
    step_t v[$];
    obs_t  got, exp;
    use_b = 1'b1;
    v.push_back(stp(1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    v.push_back(stp(0, 1, 60, 0, 0, 0, 0, 0, 60, 1, 0, 0, 0));
    v.push_back(stp(0, 0, 0,  0, 0, 0, 0, 0, 61, 1, 0, 0, 1));
    v.push_back(stp(0, 0, 0,  0, 0, 0, 0, 0, 62, 1, 0, 0, 2));
    v.push_back(stp(0, 0, 0,  0, 0, 0, 0, 0, 63, 1, 0, 0, 3));
    v.push_back(stp(0, 0, 0,  0, 0, 0, 0, 0, 64, 0, 1, 1, 4));
    v.push_back(stp(0, 1, 70, 0, 0, 0, 0, 0, 70, 0, 1, 1, 0));
    v.push_back(stp(0, 1, 63, 0, 0, 0, 0, 0, 63, 1, 0, 0, 0));
    v.push_back(stp(0, 0, 0,  0, 1, 0, 0, 0, 63, 0, 1, 0, 1));
    v.push_back(stp(0, 1, 2,  0, 0, 0, 0, 0, 2,  1, 0, 0, 0));
    v.push_back(stp(0, 0, 0,  0, 0, 1, 0, 'h3FE, 0, 1, 0, 0, 1));
    v.push_back(stp(0, 0, 0,  0, 0, 1, 0, 'h3FF, 1023, 0, 1, 1, 2));
    foreach (v[i]) begin
      apply(v[i]);
      got = sample(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL range[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_start_ignored();
    step_t v[$];
    obs_t  got, exp;
    use_b = 1'b0;
    v.push_back(stp(1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    v.push_back(stp(0, 1, 30, 0, 0, 0, 0, 0, 30, 1, 0, 0, 0));
    v.push_back(stp(0, 1, 50, 0, 0, 0, 0, 0, 31, 1, 0, 0, 1));
    v.push_back(stp(1, 1, 50, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    v.push_back(stp(0, 1, 50, 0, 0, 0, 0, 0, 50, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      got = sample(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL start_ignored[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_saturate();
    step_t v[$];
    obs_t  got, exp;
    use_b = 1'b1;
    v.push_back(stp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(stp(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 20; k++)
      v.push_back(stp(0, 0, 0, 0, 0, 0, 0, 0, k, 1, 0, 0, (k > 15) ? 15 : k));
    v.push_back(stp(0, 0, 0, 0, 1, 0, 0, 0, 20, 0, 1, 0, 15));
    v.push_back(stp(0, 1, 2, 0, 0, 0, 0, 0, 2,  1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      got = sample(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_halt();
    test_branch();
    test_stall();
    test_range();
    test_start_ignored();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL provide parameter PC_W, default 10, program counter width in bits.
REQ-002 The block SHALL provide parameter IMEM_DEPTH, default 1024, number of valid instruction addresses (2..2^PC_W).
REQ-003 The block SHALL provide parameter CYC_W, default 16, executed-cycle counter width.
REQ-004 The block SHALL provide port clk, input, 1, rising-edge clock for all state.
REQ-005 The block SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL provide port start, input, 1, single-cycle request to begin a program.
REQ-007 The block SHALL provide port entry_addr, input, PC_W, PC loaded when start is accepted.
REQ-008 The block SHALL provide port stall, input, 1, current instruction not complete; hold PC.
REQ-009 The block SHALL provide port halt, input, 1, current instruction is a halt.
REQ-010 The block SHALL provide port br_en, input, 1, current instruction takes a branch.
REQ-011 The block SHALL provide port br_abs, input, 1, 1 = absolute target, 0 = PC-relative offset.
REQ-012 The block SHALL provide port br_target, input, PC_W, absolute address or two's-complement offset.
REQ-013 The block SHALL provide port pc, output, PC_W, current fetch address.
REQ-014 The block SHALL provide port fetch_en, output, 1, instruction at pc is being executed this cycle.
REQ-015 The block SHALL provide port busy, output, 1, program running.
REQ-016 The block SHALL provide port done, output, 1, program finished; held until next start or reset.
REQ-017 The block SHALL provide port fault, output, 1, program ended by out-of-range PC.
REQ-018 The block SHALL provide port cycle_count, output, CYC_W, cycles spent in RUN.

Function
REQ-019 States SHALL be IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-020 IDLE or DONE with start=1 SHALL, next edge: pc<=entry_addr, cycle_count<=0, fault<=0, state<=RUN.
REQ-021 start in RUN SHALL be ignored.
REQ-022 If entry_addr >= IMEM_DEPTH at start, the block SHALL go to DONE with fault=1 and pc<=entry_addr.
REQ-023 fetch_en SHALL be combinational: busy and not stall.
REQ-024 In RUN, cycle_count SHALL increment every cycle, including stall cycles, and saturate at 2^CYC_W-1.
REQ-025 In RUN, per-cycle priority SHALL be stall > halt > br_en > sequential.
REQ-026 In RUN with stall=1, pc and state SHALL hold; halt/br_en are ignored.
REQ-027 In RUN with halt=1, state<=DONE next edge; pc holds at the halt address.
REQ-028 In RUN with br_en=1, br_abs=1, next pc SHALL be br_target.
REQ-029 In RUN with br_en=1, br_abs=0, next pc SHALL be (pc + br_target) mod 2^PC_W, offset sign-extended.
REQ-030 In RUN with no event, next pc SHALL be (pc + 1) mod 2^PC_W.
REQ-031 If a computed next pc >= IMEM_DEPTH, the block SHALL enter DONE with fault=1 and pc<=computed value.
REQ-032 PC update latency SHALL be exactly one clock after the controlling inputs are sampled.
REQ-033 Inputs halt, br_en, br_abs, br_target, stall SHALL be ignored outside RUN.

Reset
REQ-034 reset=1 SHALL, on the next edge, force state IDLE, pc=0, cycle_count=0, fault=0, busy=0, done=0, fetch_en=0.
REQ-035 reset SHALL take priority over start and abort a program mid-RUN without reaching DONE.

Verification
REQ-036 The bench SHALL cover: reset; start with entry_addr=5; 3 idle cycles; halt -> pc goes 5,6,7,8 then holds 8; done=1; cycle_count=4.
REQ-037 The bench SHALL cover: RUN at pc=20, br_en=1, br_abs=0, br_target=-3 (PC_W=10: 0x3FD) -> pc=17; br_abs=1, br_target=100 -> pc=100.
REQ-038 The bench SHALL cover: RUN at pc=9, stall=1 for 3 cycles with halt=1 -> pc stays 9, busy=1, fetch_en=0; stall drops -> DONE next edge.
REQ-039 The bench SHALL cover: IMEM_DEPTH=64, pc=63, no event -> DONE, fault=1, pc=64; start with entry_addr=70 -> DONE, fault=1 immediately.
REQ-040 The bench SHALL cover: start during RUN -> ignored; reset asserted mid-RUN with start=1 -> IDLE, pc=0, done=0.
REQ-041 The bench SHALL cover: CYC_W=4, 20 RUN cycles -> cycle_count saturates at 15; a new start clears it to 0.
